// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin, packet-locked arbiter sharing the write port of one fifo_async
// among N_REQ requesters in the FIFO write-clock domain. One requester owns the
// FIFO push interface at a time. Ownership is held until that requester's
// packet ends (req_last on a transfer) or MAX_BURST beats have been moved.
//
// Ports
//   clk         FIFO write clock (w_clk)
//   n_rst       asynchronous, active-low reset
//   req_valid   per-requester beat valid                      [N_REQ]
//   req_data    requester i at bits [i*WIDTH +: WIDTH]        [N_REQ*WIDTH]
//   req_last    last beat of a packet, sampled on a transfer  [N_REQ]
//   req_ready   per-requester beat accept                     [N_REQ]
//   fifo_data   to FIFO w_data                                [WIDTH]
//   fifo_push   to FIFO push
//   fifo_full   from FIFO w_full
//   grant_id    registered index of the current owner         [IDW]
//   busy        registered, a grant is held (state GRANT)
//   dbg_state   FSM state (0 = IDLE, 1 = GRANT)
//   dbg_rr_ptr  round-robin search start for the next grant   [IDW]
//
// Handshake: a beat moves on a clock edge where req_valid[i] and req_ready[i]
// are both 1. A requester holds valid/data/last stable until that edge.
// req_ready is only ever offered to the owner, and only while the FIFO is not
// full; fifo_push is exactly "owner valid and ready", so the FIFO never sees a
// push while full.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int WIDTH     = 32,
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 8
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*WIDTH-1:0]     req_data,
   input  logic [N_REQ-1:0]           req_last,
   output logic [N_REQ-1:0]           req_ready,
   output logic [WIDTH-1:0]           fifo_data,
   output logic                       fifo_push,
   input  logic                       fifo_full,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       busy,
   output logic                       dbg_state,
   output logic [$clog2(N_REQ)-1:0]   dbg_rr_ptr
);

   localparam int IDW = $clog2(N_REQ);
   localparam int BCW = $clog2(MAX_BURST + 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t           state, state_d;
   logic [IDW-1:0]   owner, owner_d;
   logic [IDW-1:0]   rr_ptr, rr_ptr_d;
   logic [BCW-1:0]   beat_cnt, beat_cnt_d;

   logic [IDW-1:0]   winner;
   logic             winner_found;
   logic [IDW-1:0]   owner_next;
   logic [WIDTH-1:0] owner_data;
   logic             transfer;
   logic             release_grant;
   int               idx;

   // ---------------------------------------------------------------------------
   // Round-robin search: first valid index at or above rr_ptr, wrapping. The
   // wrap is an explicit subtraction so N_REQ need not be a power of two.
   // ---------------------------------------------------------------------------
   always_comb begin
      winner       = '0;
      winner_found = 1'b0;
      idx          = 0;
      for (int off = 0; off < N_REQ; off++) begin
         idx = int'(rr_ptr) + off;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         if (!winner_found && req_valid[idx]) begin
            winner       = IDW'(idx);
            winner_found = 1'b1;
         end
      end
   end

   // Next search start after the current owner, wrapped explicitly.
   assign owner_next = (owner == IDW'(N_REQ - 1)) ? '0 : owner + 1'b1;

   // Owner data goes straight to the FIFO; no register on this path.
   assign owner_data = req_data[owner*WIDTH +: WIDTH];

   assign transfer      = (state == ST_GRANT) && req_valid[owner] && !fifo_full;
   assign release_grant = transfer &&
                          (req_last[owner] || (beat_cnt == BCW'(MAX_BURST - 1)));

   // ---------------------------------------------------------------------------
   // Next-state and combinational outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state;
      owner_d    = owner;
      rr_ptr_d   = rr_ptr;
      beat_cnt_d = beat_cnt;
      req_ready  = '0;
      fifo_push  = 1'b0;
      fifo_data  = '0;

      case (state)
         ST_IDLE: begin
            if (winner_found) begin
               owner_d    = winner;
               beat_cnt_d = '0;
               state_d    = ST_GRANT;
            end
         end

         ST_GRANT: begin
            req_ready[owner] = !fifo_full;
            fifo_push        = req_valid[owner] && !fifo_full;
            fifo_data        = owner_data;
            if (transfer) begin
               beat_cnt_d = beat_cnt + 1'b1;
               // Burst cap releases even mid-packet; the rest of that packet
               // competes again as a fresh grant.
               if (release_grant) begin
                  state_d  = ST_IDLE;
                  rr_ptr_d = owner_next;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= ST_IDLE;
         owner    <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_d;
         owner    <= owner_d;
         rr_ptr   <= rr_ptr_d;
         beat_cnt <= beat_cnt_d;
      end
   end

   assign grant_id   = owner;
   assign busy       = (state == ST_GRANT);
   assign dbg_state  = state;
   assign dbg_rr_ptr = rr_ptr;

   // The FIFO must never be pushed while it reports full.
   push_while_full_a : assert property (
      @(posedge clk) disable iff (!n_rst) !(fifo_push && fifo_full)
   );

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for fifo_wr_arbiter (WIDTH=32, N_REQ=4, MAX_BURST=8).
// A vector table covers a single 3-beat packet, round-robin rotation and FIFO
// backpressure cycle by cycle; hand-written sequences cover the burst cap,
// an owner stall and reset in the middle of a packet.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int MB = 8;

   // ---------------------------------------------------------------- clock/reset
   logic           clk = 1'b0;
   logic           n_rst = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_data = '0;
   logic [N-1:0]   req_last = '0;
   logic [N-1:0]   req_ready;
   logic [W-1:0]   fifo_data;
   logic           fifo_push;
   logic           fifo_full = 1'b0;
   logic [1:0]     grant_id;
   logic           busy;
   logic           dbg_state;
   logic [1:0]     dbg_rr_ptr;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.WIDTH(W), .N_REQ(N), .MAX_BURST(MB)) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .fifo_data  (fifo_data),
      .fifo_push  (fifo_push),
      .fifo_full  (fifo_full),
      .grant_id   (grant_id),
      .busy       (busy),
      .dbg_state  (dbg_state),
      .dbg_rr_ptr (dbg_rr_ptr)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // ------------------------------------------------------------------ scoreboard
   logic [W-1:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Beat payload: requester id in the top byte, tag in the low byte.
   function automatic logic [W-1:0] mk(input int id, input int tag);
      return {8'(id), 16'h0000, 8'(tag)};
   endfunction

   // ------------------------------------------------------------------ drivers
   task automatic do_reset();
      n_rst     = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   // Per-requester packet sources used by the sequences.
   int src_len[N];
   int src_start[N];
   int src_pos[N];
   int hold_id;
   int hold_lo;
   int hold_hi;

   task automatic clear_src();
      for (int i = 0; i < N; i++) begin
         src_len[i]   = 0;
         src_start[i] = 0;
         src_pos[i]   = 0;
      end
      hold_id = -1;
      hold_lo = -1;
      hold_hi = -2;
   endtask

   task automatic run_src(input int max_cyc, input string tag);
      int  c;
      bit  done;
      c    = 0;
      done = 1'b0;
      while (!done && c < max_cyc) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            req_valid[i] = (c >= src_start[i]) && (src_pos[i] < src_len[i]) &&
                           !(i == hold_id && c >= hold_lo && c <= hold_hi);
            req_data[i*W +: W] = mk(i, src_pos[i]);
            req_last[i] = (src_pos[i] == src_len[i] - 1);
         end
         #3;
         if (c >= hold_lo && c <= hold_hi) begin
            chk($sformatf("%s_c%0d_busy", tag, c), 32'(busy), 32'd1);
            chk($sformatf("%s_c%0d_gid", tag, c), 32'(grant_id), 32'(hold_id));
            chk($sformatf("%s_c%0d_push", tag, c), 32'(fifo_push), 32'd0);
         end
         @(negedge clk);
         if (fifo_push) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL %s_extra_push: got %h expected no push", tag, fifo_data);
            end else begin
               chk($sformatf("%s_order", tag), fifo_data, exp_q.pop_front());
            end
         end
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) src_pos[i]++;
         end
         done = 1'b1;
         for (int i = 0; i < N; i++) begin
            if (src_pos[i] < src_len[i]) done = 1'b0;
         end
         c++;
      end
      req_valid = '0;
      req_last  = '0;
      chk({tag, "_all_sent"}, 32'(done), 32'd1);
      chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   // ------------------------------------------------------------------ vectors
   typedef struct {
      logic [3:0] valid;
      logic [3:0] last;
      logic       full;
      logic       exp_busy;
      logic [1:0] exp_gid;
      logic       exp_push;
      logic [3:0] exp_ready;
      int         exp_src;   // requester whose data is on fifo_data, -1 = zero
      logic [1:0] exp_rr;
   } vec_t;

   localparam int NV = 22;
   vec_t vt[NV];

   initial begin
      // single 3-beat packet from req 2
      vt[0]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, -1, 2'd0};
      vt[1]  = '{4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100,  2, 2'd0};
      vt[2]  = '{4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100,  2, 2'd0};
      vt[3]  = '{4'b0100, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100,  2, 2'd0};
      vt[4]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000, -1, 2'd3};
      // all valid, 1-beat packets: order 3,0,1,2 with one bubble each
      vt[5]  = '{4'b1111, 4'b1111, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000, -1, 2'd3};
      vt[6]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000,  3, 2'd3};
      vt[7]  = '{4'b1111, 4'b1111, 1'b0, 1'b0, 2'd3, 1'b0, 4'b0000, -1, 2'd0};
      vt[8]  = '{4'b1111, 4'b1111, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001,  0, 2'd0};
      vt[9]  = '{4'b1111, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, -1, 2'd1};
      vt[10] = '{4'b1111, 4'b1111, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010,  1, 2'd1};
      vt[11] = '{4'b1111, 4'b1111, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0000, -1, 2'd2};
      vt[12] = '{4'b1111, 4'b1111, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100,  2, 2'd2};
      // req 0 packet, FIFO full for 5 cycles after the first beat
      vt[13] = '{4'b0001, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000, -1, 2'd3};
      vt[14] = '{4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001,  0, 2'd3};
      vt[15] = '{4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0000,  0, 2'd3};
      vt[16] = '{4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0000,  0, 2'd3};
      vt[17] = '{4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0000,  0, 2'd3};
      vt[18] = '{4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0000,  0, 2'd3};
      vt[19] = '{4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0000,  0, 2'd3};
      vt[20] = '{4'b0001, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001,  0, 2'd3};
      vt[21] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, -1, 2'd1};

      // ---------------------------------------------------------- reset state
      do_reset();
      chk("rst_busy",  32'(busy),       32'd0);
      chk("rst_gid",   32'(grant_id),   32'd0);
      chk("rst_push",  32'(fifo_push),  32'd0);
      chk("rst_ready", 32'(req_ready),  32'd0);
      chk("rst_data",  fifo_data,       32'd0);
      chk("rst_rr",    32'(dbg_rr_ptr), 32'd0);
      chk("rst_state", 32'(dbg_state),  32'd0);

      // ---------------------------------------------------------- table
      for (int k = 0; k < NV; k++) begin
         @(posedge clk);
         #1;
         req_valid = vt[k].valid;
         req_last  = vt[k].last;
         fifo_full = vt[k].full;
         for (int i = 0; i < N; i++) req_data[i*W +: W] = mk(i, k);
         #3;
         chk($sformatf("row%0d_busy", k),  32'(busy),       32'(vt[k].exp_busy));
         chk($sformatf("row%0d_gid", k),   32'(grant_id),   32'(vt[k].exp_gid));
         chk($sformatf("row%0d_push", k),  32'(fifo_push),  32'(vt[k].exp_push));
         chk($sformatf("row%0d_ready", k), 32'(req_ready),  32'(vt[k].exp_ready));
         chk($sformatf("row%0d_data", k),  fifo_data,
             (vt[k].exp_src < 0) ? 32'd0 : mk(vt[k].exp_src, k));
         chk($sformatf("row%0d_rr", k),    32'(dbg_rr_ptr), 32'(vt[k].exp_rr));
      end

      // ---------------------------------------------------------- burst cap
      // req 1: 12-beat packet; req 3: 2-beat packet arriving one cycle later.
      do_reset();
      clear_src();
      src_len[1] = 12;
      src_len[3] = 2;
      src_start[3] = 1;
      for (int b = 0; b < 8; b++)  exp_q.push_back(mk(1, b));
      for (int b = 0; b < 2; b++)  exp_q.push_back(mk(3, b));
      for (int b = 8; b < 12; b++) exp_q.push_back(mk(1, b));
      run_src(60, "burst");

      // ---------------------------------------------------------- owner stall
      // req 2 owns a 4-beat packet and drops valid for 3 cycles after 2 beats;
      // req 0 waits the whole time.
      do_reset();
      clear_src();
      src_len[2] = 4;
      src_len[0] = 1;
      src_start[0] = 2;
      hold_id = 2;
      hold_lo = 3;
      hold_hi = 5;
      for (int b = 0; b < 4; b++) exp_q.push_back(mk(2, b));
      exp_q.push_back(mk(0, 0));
      run_src(40, "stall");

      // ---------------------------------------------------------- reset mid-packet
      do_reset();
      req_valid = 4'b0010;
      req_last  = 4'b0010;
      req_data[1*W +: W] = mk(1, 0);
      @(posedge clk); #1;                 // req 1 granted, beat moves next edge
      @(posedge clk); #1;                 // released, rr_ptr = 2
      chk("mid_rr_before", 32'(dbg_rr_ptr), 32'd2);
      req_valid = 4'b1000;
      req_last  = 4'b0000;
      req_data[3*W +: W] = mk(3, 0);
      @(posedge clk); #1;
      chk("mid_push_b0", 32'(fifo_push), 32'd1);
      chk("mid_gid_b0",  32'(grant_id),  32'd3);
      req_data[3*W +: W] = mk(3, 1);
      @(posedge clk); #1;
      chk("mid_data_b1", fifo_data, mk(3, 1));
      req_data[3*W +: W] = mk(3, 2);
      @(posedge clk); #1;
      chk("mid_busy_b2", 32'(busy), 32'd1);
      n_rst = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(req_ready),  32'd0);
      chk("mid_rst_push",  32'(fifo_push),  32'd0);
      chk("mid_rst_data",  fifo_data,       32'd0);
      chk("mid_rst_gid",   32'(grant_id),   32'd0);
      chk("mid_rst_busy",  32'(busy),       32'd0);
      chk("mid_rst_rr",    32'(dbg_rr_ptr), 32'd0);
      req_valid = 4'b1001;
      req_data[0*W +: W] = mk(0, 0);
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_busy",  32'(busy),      32'd1);
      chk("post_rst_gid",   32'(grant_id),  32'd0);
      chk("post_rst_ready", 32'(req_ready), 32'd1);
      chk("post_rst_data",  fifo_data,      mk(0, 0));
      req_valid = '0;
      repeat (2) @(posedge clk);

      // ---------------------------------------------------------- report
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Bound on total run time.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
